// File: rtl/sub_pkg.sv
// Shared constants for the subtractor slice.
package sub_pkg;
  localparam int DEFAULT_WIDTH = 64;
endpackage

// File: rtl/sub_full_adder.sv
// One-bit full adder cell for the ripple-carry chain.
// Combinational; no latency, no backpressure.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sub.sv
// Registered two's complement subtractor Y = A - B with unsigned no-borrow flag.
// 1-cycle latency, one result per cycle; no handshake, inputs sampled every edge.
module sub
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             c_out,
  input  logic             clk,
  input  logic             rst
);

  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   carry;

  // Subtraction as A + ~B + 1: the +1 enters as the chain's carry-in.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a   (A[i]),
      .b   (~B[i]),
      .cin (carry[i]),
      .sum (diff[i]),
      .cout(carry[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y     <= '0;
      c_out <= 1'b0;
    end else begin
      Y     <= diff;
      c_out <= carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_sub.sv
// Directed self-checking bench for the registered subtractor.
module tb_sub;
  localparam int W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};

  logic [W-1:0] A, B, Y;
  logic c_out, clk, rst;
  int total = 0;
  int bad = 0;

  sub #(.WIDTH(W)) dut (.A(A), .B(B), .Y(Y), .c_out(c_out), .clk(clk), .rst(rst));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands away from the edge, then step past the next rising edge.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    total++;
    if (Y !== '0) begin bad++; $display("FAIL reset_y got=%h exp=0", Y); end
    total++;
    if (c_out !== 1'b0) begin bad++; $display("FAIL reset_c got=%b exp=0", c_out); end
    @(posedge clk);
    #1;
    total++;
    if (Y !== '0) begin bad++; $display("FAIL reset_hold_y got=%h exp=0", Y); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [W-1:0] va [6] = '{64'd0, -64'sd2, 64'd3, 64'h1234, 64'd10, ONES};
    logic [W-1:0] vb [6] = '{64'd1, 64'd2, 64'd0, 64'h1234, -64'sd2, ONES};
    logic [W-1:0] vy [6] = '{ONES, -64'sd4, 64'd3, 64'd0, 64'd12, 64'd0};
    logic         vc [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i]);
      total++;
      if (Y !== vy[i]) begin bad++; $display("FAIL basic_y[%0d] got=%h exp=%h", i, Y, vy[i]); end
      total++;
      if (c_out !== vc[i]) begin bad++; $display("FAIL basic_c[%0d] got=%b exp=%b", i, c_out, vc[i]); end
    end
  endtask

  task automatic test_wrap;
    drive(MINV, 64'd1);
    total++;
    if (Y !== MAXV) begin bad++; $display("FAIL wrap_min_y got=%h exp=%h", Y, MAXV); end
    total++;
    if (c_out !== 1'b1) begin bad++; $display("FAIL wrap_min_c got=%b exp=1", c_out); end
    drive(MAXV, ONES);
    total++;
    if (Y !== MINV) begin bad++; $display("FAIL wrap_max_y got=%h exp=%h", Y, MINV); end
    total++;
    if (c_out !== 1'b0) begin bad++; $display("FAIL wrap_max_c got=%b exp=0", c_out); end
  endtask

  task automatic test_back_to_back;
    drive(64'd100, 64'd1);
    total++;
    if (Y !== 64'd99) begin bad++; $display("FAIL b2b_0 got=%h exp=%h", Y, 64'd99); end
    drive(64'd7, 64'd9);
    total++;
    if (Y !== -64'sd2 || c_out !== 1'b0) begin
      bad++; $display("FAIL b2b_1 got=%h/%b exp=%h/0", Y, c_out, -64'sd2);
    end
    // Changing inputs between edges must not disturb the registered result.
    @(negedge clk);
    A = 64'd50;
    B = 64'd20;
    #1;
    total++;
    if (Y !== -64'sd2) begin bad++; $display("FAIL b2b_hold got=%h exp=%h", Y, -64'sd2); end
    @(posedge clk);
    #1;
    total++;
    if (Y !== 64'd30 || c_out !== 1'b1) begin
      bad++; $display("FAIL b2b_2 got=%h/%b exp=%h/1", Y, c_out, 64'd30);
    end
  endtask

  task automatic test_mid_reset;
    drive(64'd5, 64'd3);
    total++;
    if (Y !== 64'd2) begin bad++; $display("FAIL mrst_pre got=%h exp=2", Y); end
    @(negedge clk);
    A = 64'd40;
    B = 64'd1;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (Y !== '0 || c_out !== 1'b0) begin
      bad++; $display("FAIL mrst_async got=%h/%b exp=0/0", Y, c_out);
    end
    @(posedge clk);
    #1;
    total++;
    if (Y !== '0 || c_out !== 1'b0) begin
      bad++; $display("FAIL mrst_held got=%h/%b exp=0/0", Y, c_out);
    end
    @(negedge clk);
    A = 64'd5;
    B = 64'd3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (Y !== 64'd2 || c_out !== 1'b1) begin
      bad++; $display("FAIL mrst_release got=%h/%b exp=2/1", Y, c_out);
    end
  endtask

  initial begin
    rst = 1'b1;
    A = '0;
    B = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
